// File: rtl/btb_pkg.sv
// Shared types and address helpers for the set-associative branch target buffer.
// Entries are sized to the widest supported PC; each instance uses the low bits it needs.
package btb_pkg;

  localparam int BTB_MAX_BITS = 64;

  typedef struct packed {
    logic                    valid;
    logic [BTB_MAX_BITS-1:0] tag;
    logic [BTB_MAX_BITS-1:0] target;
  } btb_entry_t;

  // pc[0] is ignored, so the set index starts at bit 1
  function automatic logic [BTB_MAX_BITS-1:0] get_index(input logic [BTB_MAX_BITS-1:0] pc,
                                                        input int idx_bits);
    logic [BTB_MAX_BITS-1:0] mask;
    mask = (BTB_MAX_BITS'(1) << idx_bits) - BTB_MAX_BITS'(1);
    return (pc >> 1) & mask;
  endfunction

  function automatic logic [BTB_MAX_BITS-1:0] get_tag(input logic [BTB_MAX_BITS-1:0] pc,
                                                      input int idx_bits);
    return pc >> (idx_bits + 1);
  endfunction

  function automatic btb_entry_t make_entry(input logic valid,
                                            input logic [BTB_MAX_BITS-1:0] tag,
                                            input logic [BTB_MAX_BITS-1:0] target);
    btb_entry_t e;
    e.valid  = valid;
    e.tag    = tag;
    e.target = target;
    return e;
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Bundle of lookup, update, invalidate and flush signals between the predictor and the BTB.
interface btb_assoc_if #(
  parameter int PC_BITS  = 32,
  parameter int RD_PORTS = 2
);
  logic [RD_PORTS-1:0][PC_BITS-1:0] lookup_pc;
  logic [RD_PORTS-1:0]              hit;
  logic [RD_PORTS-1:0][PC_BITS-1:0] target;
  logic                             wr_en;
  logic [PC_BITS-1:0]               wr_pc;
  logic [PC_BITS-1:0]               wr_target;
  logic                             inv_en;
  logic [PC_BITS-1:0]               inv_pc;
  logic                             flush;
  logic                             evict;

  modport master (
    output lookup_pc, wr_en, wr_pc, wr_target, inv_en, inv_pc, flush,
    input  hit, target, evict
  );

  modport slave (
    input  lookup_pc, wr_en, wr_pc, wr_target, inv_en, inv_pc, flush,
    output hit, target, evict
  );
endinterface

// File: rtl/btb_set_lookup.sv
// Tag compare across all ways of one set: hit flag, lowest matching way (index and
// one-hot) and that way's target, or zero on a miss.
module btb_set_lookup
  import btb_pkg::*;
#(
  parameter int WAYS     = 4,
  parameter int TAG_BITS = 22,
  parameter int PC_BITS  = 32,
  parameter int PTR_BITS = 2
) (
  input  btb_entry_t          entries [WAYS],
  input  logic [TAG_BITS-1:0] tag,
  output logic                hit,
  output logic [WAYS-1:0]     hit_onehot,
  output logic [PTR_BITS-1:0] hit_way,
  output logic [PC_BITS-1:0]  target
);

  logic [WAYS-1:0] match;
  logic [WAYS-1:0] unused_par;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign match[gi]      = entries[gi].valid && (entries[gi].tag[TAG_BITS-1:0] == tag);
      assign unused_par[gi] = ^entries[gi];
    end
  endgenerate

  // Descending scan so the lowest matching way is the one that sticks
  always_comb begin
    hit        = |match;
    hit_onehot = match & (~match + WAYS'(1));
    hit_way    = '0;
    target     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) begin
        hit_way = PTR_BITS'(w);
        target  = entries[w].target[PC_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative multi-port branch target buffer with round-robin replacement,
// tag-matched invalidation, global flush and a registered eviction pulse.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int PC_BITS  = 32,
  parameter int SETS     = 256,
  parameter int WAYS     = 4,
  parameter int RD_PORTS = 2
) (
  input  logic        clk,
  input  logic        rst,
  btb_assoc_if.slave  bus
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = PC_BITS - IDX_BITS - 1;
  localparam int PTR_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Lookups must be combinational on many ports, so tag/target live in flops (no reset)
  logic [TAG_BITS-1:0] tag_mem    [SETS][WAYS];
  logic [PC_BITS-1:0]  tgt_mem    [SETS][WAYS];
  logic [WAYS-1:0]     valid_reg  [SETS];
  logic [PTR_BITS-1:0] rr_ptr_reg [SETS];
  logic                evict_reg;

  logic [RD_PORTS-1:0]              rd_hit;
  logic [RD_PORTS-1:0][PC_BITS-1:0] rd_target;

  genvar gi;
  generate
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic [IDX_BITS-1:0] idx;
      logic [TAG_BITS-1:0] tag;
      btb_entry_t          ents [WAYS];
      logic [WAYS-1:0]     unused_oh;
      logic [PTR_BITS-1:0] unused_way;

      assign idx = IDX_BITS'(get_index(BTB_MAX_BITS'(bus.lookup_pc[gi]), IDX_BITS));
      assign tag = TAG_BITS'(get_tag(BTB_MAX_BITS'(bus.lookup_pc[gi]), IDX_BITS));

      always_comb begin
        for (int w = 0; w < WAYS; w++) begin
          ents[w] = make_entry(valid_reg[idx][w], BTB_MAX_BITS'(tag_mem[idx][w]),
                               BTB_MAX_BITS'(tgt_mem[idx][w]));
        end
      end

      btb_set_lookup #(
        .WAYS(WAYS), .TAG_BITS(TAG_BITS), .PC_BITS(PC_BITS), .PTR_BITS(PTR_BITS)
      ) u_lookup (
        .entries(ents), .tag(tag), .hit(rd_hit[gi]), .hit_onehot(unused_oh),
        .hit_way(unused_way), .target(rd_target[gi])
      );
    end
  endgenerate

  assign bus.hit    = rd_hit;
  assign bus.target = rd_target;
  assign bus.evict  = evict_reg;

  // Write and invalidate matching against pre-edge contents
  logic [IDX_BITS-1:0] wr_idx, inv_idx;
  logic [TAG_BITS-1:0] wr_tag, inv_tag;
  btb_entry_t          wr_ents  [WAYS];
  btb_entry_t          inv_ents [WAYS];
  logic                wr_hit, inv_hit;
  logic [WAYS-1:0]     wr_onehot, inv_onehot;
  logic [PTR_BITS-1:0] unused_wr_way, unused_inv_way;
  logic [PC_BITS-1:0]  unused_wr_tgt, unused_inv_tgt;

  assign wr_idx  = IDX_BITS'(get_index(BTB_MAX_BITS'(bus.wr_pc), IDX_BITS));
  assign wr_tag  = TAG_BITS'(get_tag(BTB_MAX_BITS'(bus.wr_pc), IDX_BITS));
  assign inv_idx = IDX_BITS'(get_index(BTB_MAX_BITS'(bus.inv_pc), IDX_BITS));
  assign inv_tag = TAG_BITS'(get_tag(BTB_MAX_BITS'(bus.inv_pc), IDX_BITS));

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      wr_ents[w]  = make_entry(valid_reg[wr_idx][w], BTB_MAX_BITS'(tag_mem[wr_idx][w]),
                               BTB_MAX_BITS'(tgt_mem[wr_idx][w]));
      inv_ents[w] = make_entry(valid_reg[inv_idx][w], BTB_MAX_BITS'(tag_mem[inv_idx][w]),
                               BTB_MAX_BITS'(tgt_mem[inv_idx][w]));
    end
  end

  btb_set_lookup #(
    .WAYS(WAYS), .TAG_BITS(TAG_BITS), .PC_BITS(PC_BITS), .PTR_BITS(PTR_BITS)
  ) u_wr_match (
    .entries(wr_ents), .tag(wr_tag), .hit(wr_hit), .hit_onehot(wr_onehot),
    .hit_way(unused_wr_way), .target(unused_wr_tgt)
  );

  btb_set_lookup #(
    .WAYS(WAYS), .TAG_BITS(TAG_BITS), .PC_BITS(PC_BITS), .PTR_BITS(PTR_BITS)
  ) u_inv_match (
    .entries(inv_ents), .tag(inv_tag), .hit(inv_hit), .hit_onehot(inv_onehot),
    .hit_way(unused_inv_way), .target(unused_inv_tgt)
  );

  // Victim choice: existing entry, else lowest free way, else round-robin pointer
  logic [WAYS-1:0]     wr_valid, free_onehot, ptr_onehot, wr_mask;
  logic [PTR_BITS-1:0] wr_ptr, ptr_next;
  logic                any_free, wr_replace, wr_drop, wr_do, inv_clear;

  always_comb begin
    wr_valid    = valid_reg[wr_idx];
    wr_ptr      = rr_ptr_reg[wr_idx];
    free_onehot = ~wr_valid & (wr_valid + WAYS'(1));
    any_free    = ~&wr_valid;
    ptr_onehot  = WAYS'(1) << wr_ptr;
    ptr_next    = (wr_ptr == PTR_BITS'(WAYS - 1)) ? '0 : wr_ptr + PTR_BITS'(1);
    wr_replace  = !wr_hit && !any_free;
    wr_mask     = wr_hit ? wr_onehot : (any_free ? free_onehot : ptr_onehot);
    wr_drop     = bus.inv_en && (inv_idx == wr_idx) && (inv_tag == wr_tag);
    wr_do       = bus.wr_en && !wr_drop;
    inv_clear   = bus.inv_en && inv_hit;
  end

  // Invalidate is applied before the write so a write landing on the same way wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s]  <= '0;
        rr_ptr_reg[s] <= '0;
      end
      evict_reg <= 1'b0;
    end else if (bus.flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s]  <= '0;
        rr_ptr_reg[s] <= '0;
      end
      evict_reg <= 1'b0;
    end else begin
      evict_reg <= wr_do && wr_replace;
      if (inv_clear) begin
        for (int w = 0; w < WAYS; w++) begin
          if (inv_onehot[w]) valid_reg[inv_idx][w] <= 1'b0;
        end
      end
      if (wr_do) begin
        for (int w = 0; w < WAYS; w++) begin
          if (wr_mask[w]) valid_reg[wr_idx][w] <= 1'b1;
        end
        if (wr_replace) rr_ptr_reg[wr_idx] <= ptr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do && !bus.flush) begin
      for (int w = 0; w < WAYS; w++) begin
        if (wr_mask[w]) begin
          tag_mem[wr_idx][w] <= wr_tag;
          tgt_mem[wr_idx][w] <= bus.wr_target;
        end
      end
    end
  end

endmodule
